// File: rtl/syn_pc_unit_pkg.sv
// Shared definitions for the program-counter stage: FSM encoding and default reset PC.
package syn_pc_unit_pkg;

  typedef enum logic {
    PC_ST_RUN  = 1'b0,
    PC_ST_HALT = 1'b1
  } pc_state_e;

  localparam logic [31:0] PC_RESET_DEF = 32'h0000_0000;
  localparam logic [31:0] PC_STEP      = 32'd4;

endpackage

// File: rtl/syn_pc_unit_stat_counter.sv
// Wrap-around event counter with synchronous active-low clear.
module syn_stat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_d;
  logic [W-1:0] cnt_q;

  // next count: +1 on inc, natural modulo-2^W wrap
  always_comb begin
    cnt_d = cnt_q;
    if (inc) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // count register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/syn_pc_unit.sv
// Program-counter stage: registers the aligned next PC, exports pc/pc+4,
// runs the RUN/HALTED control and keeps instruction/branch/jump statistics.
module syn_pc_unit
  import syn_pc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = PC_RESET_DEF,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [31:0]      pc_new,
  input  logic             branched,
  input  logic             is_jump,
  input  logic             halt,
  input  logic             resume,
  output logic [31:0]      pc,
  output logic [31:0]      pc_4,
  output logic             halted,
  output logic [CNT_W-1:0] cnt_instr,
  output logic [CNT_W-1:0] cnt_branch,
  output logic [CNT_W-1:0] cnt_jump
);

  pc_state_e   state_d;
  pc_state_e   state_q;
  logic [31:0] pc_d;
  logic [31:0] pc_q;
  logic        step_run_s;
  logic [2:0]  inc_s;
  logic        unused_pc_low_s;

  assign unused_pc_low_s = ^pc_new[1:0];
  assign pc_4            = pc_q + PC_STEP;
  assign step_run_s      = en & (state_q == PC_ST_RUN);
  assign inc_s           = {3{step_run_s}} & {1'b1, branched, is_jump};

  // next-state and next-pc; halt takes priority, resume only matters in HALTED
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (en) begin
      case (state_q)
        PC_ST_RUN: begin
          if (halt) begin
            state_d = PC_ST_HALT;
          end else begin
            pc_d = {pc_new[31:2], 2'b00};
          end
        end
        PC_ST_HALT: begin
          if (resume) begin
            pc_d    = pc_4;
            state_d = PC_ST_RUN;
          end else begin
            state_d = PC_ST_HALT;
          end
        end
        default: begin
          state_d = PC_ST_RUN;
        end
      endcase
    end else begin
      state_d = state_q;
      pc_d    = pc_q;
    end
  end

  // pc and FSM state registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= PC_ST_RUN;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign pc     = pc_q;
  assign halted = (state_q == PC_ST_HALT);

  syn_stat_counter #(.W(CNT_W)) u_cnt_instr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (inc_s[2]),
    .cnt   (cnt_instr)
  );

  syn_stat_counter #(.W(CNT_W)) u_cnt_branch (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (inc_s[1]),
    .cnt   (cnt_branch)
  );

  syn_stat_counter #(.W(CNT_W)) u_cnt_jump (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (inc_s[0]),
    .cnt   (cnt_jump)
  );

endmodule

// File: tb/tb_syn_pc_unit.sv
// Self-checking bench for syn_pc_unit: directed scenarios plus random stimulus,
// compared every cycle against a behavioural model of the PC stage.
module tb_syn_pc_unit;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n, en, branched, is_jump, halt, resume;
  logic [31:0]   pc_new;
  logic [31:0]   pc, pc_4;
  logic          halted;
  logic [CW-1:0] cnt_instr, cnt_branch, cnt_jump;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  logic [31:0]   m_pc;
  bit            m_halted;
  logic [CW-1:0] m_ci, m_cb, m_cj;

  always #5 clk = ~clk;

  syn_pc_unit #(.RESET_PC(32'h0000_0000), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .pc_new     (pc_new),
    .branched   (branched),
    .is_jump    (is_jump),
    .halt       (halt),
    .resume     (resume),
    .pc         (pc),
    .pc_4       (pc_4),
    .halted     (halted),
    .cnt_instr  (cnt_instr),
    .cnt_branch (cnt_branch),
    .cnt_jump   (cnt_jump)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: what one clock edge must do to the architectural state
  always @(posedge clk) begin
    if (!rst_n) begin
      m_pc <= 32'h0; m_halted <= 1'b0; m_ci <= '0; m_cb <= '0; m_cj <= '0;
    end else if (en) begin
      if (!m_halted) begin
        m_ci <= m_ci + 1'b1;
        if (branched) m_cb <= m_cb + 1'b1;
        if (is_jump)  m_cj <= m_cj + 1'b1;
        if (halt) m_halted <= 1'b1;
        else      m_pc <= pc_new & 32'hFFFF_FFFC;
      end else if (resume) begin
        m_pc     <= m_pc + 32'd4;
        m_halted <= 1'b0;
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("pc",         pc,                   m_pc);
      chk("pc_4",       pc_4,                 m_pc + 32'd4);
      chk("halted",     {31'd0, halted},      {31'd0, m_halted});
      chk("cnt_instr",  {28'd0, cnt_instr},   {28'd0, m_ci});
      chk("cnt_branch", {28'd0, cnt_branch},  {28'd0, m_cb});
      chk("cnt_jump",   {28'd0, cnt_jump},    {28'd0, m_cj});
    end
  end

  task automatic cyc(input logic r, input logic e, input logic [31:0] pn,
                     input logic b, input logic j, input logic h, input logic rs);
    rst_n = r; en = e; pc_new = pn; branched = b; is_jump = j; halt = h; resume = rs;
    @(negedge clk);
  endtask

  task automatic step(input logic [31:0] pn, input logic b, input logic j);
    cyc(1'b1, 1'b1, pn, b, j, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; pc_new = 32'h1234; branched = 1'b0;
    is_jump = 1'b0; halt = 1'b0; resume = 1'b0;

    // 1 reset
    cyc(1'b0, 1'b1, 32'h1234, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_en = 1'b1;
    cyc(1'b0, 1'b1, 32'h1234, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t1_pc", pc, 32'h0);
    chk("t1_pc4", pc_4, 32'h4);
    chk("t1_halted", {31'd0, halted}, 32'd0);
    chk("t1_cnt", {28'd0, cnt_instr}, 32'd0);
    step(32'h10, 1'b0, 1'b0);
    chk("t1_pc_after", pc, 32'h10);
    chk("t1_ci_after", {28'd0, cnt_instr}, 32'd1);

    // 2 alignment and stall
    step(32'h43, 1'b0, 1'b0);
    chk("t2_align", pc, 32'h40);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 32'h80, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t2_stall_pc", pc, 32'h40);
    chk("t2_stall_ci", {28'd0, cnt_instr}, 32'd2);
    chk("t2_stall_cb", {28'd0, cnt_branch}, 32'd0);

    // 3 counting
    cyc(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++)
      step(32'h100 * i, (i == 2) || (i == 4), (i == 5));
    chk("t3_ci", {28'd0, cnt_instr}, 32'd5);
    chk("t3_cb", {28'd0, cnt_branch}, 32'd2);
    chk("t3_cj", {28'd0, cnt_jump}, 32'd1);

    // 4 halt / resume
    step(32'h3000, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 32'h5000, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("t4_halt_pc", pc, 32'h3000);
    chk("t4_halted", {31'd0, halted}, 32'd1);
    chk("t4_ci", {28'd0, cnt_instr}, 32'd7);
    for (int i = 0; i < 4; i++)
      cyc(1'b1, 1'b1, $urandom, 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    chk("t4_idle_pc", pc, 32'h3000);
    chk("t4_idle_ci", {28'd0, cnt_instr}, 32'd7);
    cyc(1'b1, 1'b0, 32'h9000, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t4_resume_en0", {31'd0, halted}, 32'd1);
    cyc(1'b1, 1'b1, 32'h9000, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t4_resume_pc", pc, 32'h3004);
    chk("t4_resume_halted", {31'd0, halted}, 32'd0);
    chk("t4_resume_ci", {28'd0, cnt_instr}, 32'd7);

    // 5 wrap
    cyc(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) step(32'h4 * i, 1'b1, 1'b1);
    chk("t5_ci_wrap", {28'd0, cnt_instr}, 32'd0);
    chk("t5_cb_wrap", {28'd0, cnt_branch}, 32'd0);
    step(32'hFFFF_FFFF, 1'b0, 1'b0);
    chk("t5_pc_top", pc, 32'hFFFF_FFFC);
    chk("t5_pc4_wrap", pc_4, 32'h0);

    // 6 reset while halted
    cyc(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(32'h200 + 32'h4 * i, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t6_pre_ci", {28'd0, cnt_instr}, 32'd7);
    chk("t6_pre_halted", {31'd0, halted}, 32'd1);
    cyc(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("t6_pc", pc, 32'h0);
    chk("t6_halted", {31'd0, halted}, 32'd0);
    chk("t6_cj", {28'd0, cnt_jump}, 32'd0);
    step(32'h20, 1'b0, 1'b0);
    chk("t6_run_pc", pc, 32'h20);

    // random phase
    for (int i = 0; i < 3000; i++)
      cyc(($urandom_range(63) != 0), ($urandom_range(3) != 0), $urandom,
          1'($urandom), 1'($urandom), ($urandom_range(7) == 0),
          ($urandom_range(3) == 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
